hf_tans_bit_packer: RTL

//  Downstream stage of the tANS recoder. Consumes its variable-length chunks (BTR = 0..3 valid bits of o_stream) and packs them LSB-first into bytes.

---
 rtl/hf_tans_pkg.sv | 29 ++
 rtl/hf_tans_byte_slot.sv | 34 +++
 rtl/hf_tans_bit_packer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hf_tans_pkg.sv
// rtl/hf_tans_pkg.sv - shared parameters, FSM encoding and mask helpers for the tANS bit packer
package hf_tans_pkg;

  localparam int ACC_W_DEF   = 16;
  localparam int STATE_W_DEF = 4;
  localparam int CHUNK_W_DEF = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH_ST = 2'd1,
    DRAIN    = 2'd2
  } packer_state_t;

  // Keep only the low btr bits of a recoder chunk.
  function automatic logic [CHUNK_W_DEF-1:0] chunk_mask(input logic [CHUNK_W_DEF-1:0] bits,
                                                         input logic [1:0] btr);
    logic [CHUNK_W_DEF-1:0] m;
    m = ~({CHUNK_W_DEF{1'b1}} << btr);
    return bits & m;
  endfunction

  function automatic logic [7:0] byte_mask(input int unsigned n);
    logic [8:0] m;
    if (n >= 8) return 8'hFF;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/hf_tans_byte_slot.sv
// rtl/hf_tans_byte_slot.sv - single-entry output byte register with valid/ready hold
module hf_tans_byte_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic [3:0] load_nb,
  input  logic       rdy,
  output logic [7:0] data,
  output logic       valid,
  output logic       last,
  output logic [3:0] nb
);

  // The producer only loads when the slot is empty or being drained this cycle,
  // so holding the fields otherwise keeps them stable across a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 8'd0;
      valid <= 1'b0;
      last  <= 1'b0;
      nb    <= 4'd0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
      nb    <= load_nb;
    end else if (valid && rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hf_tans_bit_packer.sv
// rtl/hf_tans_bit_packer.sv - packs variable-length tANS chunks LSB-first into bytes,
// appends the final coder state on flush and drains a padded LAST byte.
module hf_tans_bit_packer
  import hf_tans_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic               PHI,
  input  logic               RST,
  input  logic               IN_V,
  input  logic [1:0]         IN_BTR,
  input  logic [CHUNK_W_DEF-1:0] IN_BITS,
  input  logic               FLUSH,
  input  logic [STATE_W-1:0] FINAL_STATE,
  output logic [7:0]         OUT_DATA,
  output logic               OUT_V,
  input  logic               OUT_RDY,
  output logic               OUT_LAST,
  output logic [3:0]         OUT_NB,
  output logic               BUSY,
  output logic               ERR
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  packer_state_t      state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] fstate;

  logic               can_emit;
  logic               want;
  logic               emit;
  logic               is_last;
  logic [7:0]         emit_data;
  logic [3:0]         emit_nb;
  logic [ACC_W-1:0]   acc_sh;
  logic [CNT_W-1:0]   cnt_ae;
  logic [CNT_W-1:0]   add_len;
  logic [ACC_W-1:0]   add_bits;
  logic               in_err;
  logic               ovf;
  logic [ACC_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   cnt_nx;

  always_comb begin
    can_emit  = !OUT_V || OUT_RDY;
    want      = (state == DRAIN) ? (cnt != '0) : (cnt >= CNT_W'(8));
    emit      = want && can_emit;
    is_last   = (state == DRAIN) && (cnt <= CNT_W'(8));
    emit_data = acc[7:0] & byte_mask(32'(cnt));
    emit_nb   = is_last ? 4'(cnt) : 4'd8;

    acc_sh = emit ? (acc >> 8) : acc;
    if (!emit)                  cnt_ae = cnt;
    else if (cnt > CNT_W'(8))   cnt_ae = cnt - CNT_W'(8);
    else                        cnt_ae = '0;

    add_len  = '0;
    add_bits = '0;
    in_err   = 1'b0;
    case (state)
      RUN: begin
        if (IN_V && (IN_BTR != 2'd0)) begin
          add_len  = CNT_W'(IN_BTR);
          add_bits = ACC_W'(chunk_mask(IN_BITS, IN_BTR));
        end
      end
      FLUSH_ST: begin
        add_len  = CNT_W'(STATE_W);
        add_bits = ACC_W'(fstate);
        in_err   = (IN_V && (IN_BTR != 2'd0)) || FLUSH;
      end
      DRAIN: begin
        in_err = (IN_V && (IN_BTR != 2'd0)) || FLUSH;
      end
      default: ;
    endcase

    // A chunk that does not fit is dropped whole so the stream never splits a symbol.
    ovf = (add_len != '0) && (({1'b0, cnt_ae} + {1'b0, add_len}) > (CNT_W + 1)'(ACC_W));
    if (ovf || (add_len == '0)) begin
      acc_nx = acc_sh;
      cnt_nx = cnt_ae;
    end else begin
      acc_nx = acc_sh | (add_bits << cnt_ae);
      cnt_nx = cnt_ae + add_len;
    end
  end

  always_ff @(posedge PHI) begin
    if (RST) begin
      state  <= RUN;
      acc    <= '0;
      cnt    <= '0;
      fstate <= '0;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      ERR <= ERR | ovf | in_err;
      case (state)
        RUN: begin
          if (FLUSH) begin
            fstate <= FINAL_STATE;
            state  <= FLUSH_ST;
            BUSY   <= 1'b1;
          end
        end
        FLUSH_ST: begin
          state <= DRAIN;
          BUSY  <= 1'b1;
        end
        DRAIN: begin
          if ((emit && is_last) || (cnt == '0)) begin
            state <= RUN;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  hf_tans_byte_slot u_slot (
    .clk       (PHI),
    .rst       (RST),
    .load      (emit),
    .load_data (emit_data),
    .load_last (is_last),
    .load_nb   (emit_nb),
    .rdy       (OUT_RDY),
    .data      (OUT_DATA),
    .valid     (OUT_V),
    .last      (OUT_LAST),
    .nb        (OUT_NB)
  );

endmodule
